alk_lit_seq: RTL and testbench

ALK_LIT_SEQ -- requirements
Module: alk_lit_seq

---
 rtl/alk_lit_seq.sv | 112 +++++++++++
 tb/tb_alk_lit_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alk_lit_seq.sv
// Immediate-literal fetch sequencer for the ALK slice: pulls one or two 16-bit
// words from the instruction buffer and assembles a sign-extended or full 32-bit literal.
module alk_lit_seq (
    input  logic        clk_h,
    input  logic        reset_h,
    input  logic        start_h,
    input  logic        size_h,
    input  logic        abort_h,
    input  logic        ib_valid_h,
    input  logic [15:0] ib_data_h,
    output logic        ib_take_h,
    output logic [3:0]  mux_h,
    output logic        long_lit_l,
    output logic [31:0] lit_h,
    output logic        busy_h,
    output logic        stall_h,
    output logic        done_h
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] MUX_NOP    = 4'b0000;
    localparam logic [3:0] MUX_LIT_LO = 4'b0100;
    localparam logic [3:0] MUX_LIT_HI = 4'b0101;

    state_t      state_q, state_d;
    logic        size_q, size_d;
    logic [31:0] lit_d;

    // NOTE: every signal driven here gets a default before the case so that no
    // path leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        lit_d   = lit_h;

        if (abort_h) begin
            state_d = S_IDLE;
            lit_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_h) begin
                        state_d = S_LO;
                        size_d  = size_h;
                    end
                end
                S_LO: begin
                    if (ib_valid_h) begin
                        lit_d[15:0] = ib_data_h;
                        if (size_q) begin
                            state_d = S_HI;
                        end else begin
                            lit_d[31:16] = {16{ib_data_h[15]}};
                            state_d      = S_DONE;
                        end
                    end
                end
                S_HI: begin
                    if (ib_valid_h) begin
                        lit_d[31:16] = ib_data_h;
                        state_d      = S_DONE;
                    end
                end
                S_DONE: begin
                    // A start here chains straight into the next literal with no IDLE gap.
                    if (start_h) begin
                        state_d = S_LO;
                        size_d  = size_h;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_h     = (state_q == S_LO) || (state_q == S_HI);
        ib_take_h  = ib_valid_h && busy_h && !abort_h;
        long_lit_l = !(busy_h && size_q);
        stall_h    = busy_h || ((state_q == S_IDLE) && start_h);
        done_h     = (state_q == S_DONE) && !abort_h;

        unique case (state_q)
            S_LO:    mux_h = MUX_LIT_LO;
            S_HI:    mux_h = MUX_LIT_HI;
            default: mux_h = MUX_NOP;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs regardless of process evaluation order.
    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            state_q <= S_IDLE;
            size_q  <= 1'b0;
            lit_h   <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            lit_h   <= lit_d;
        end
    end

endmodule

// File: tb/tb_alk_lit_seq.sv
// Randomized scoreboard bench for alk_lit_seq: a transaction-level literal-fetch
// model predicts per-cycle outputs and completed literals; a monitor compares.
module tb_alk_lit_seq;

    logic        clk_h = 1'b0;
    logic        reset_h;
    logic        start_h;
    logic        size_h;
    logic        abort_h;
    logic        ib_valid_h;
    logic [15:0] ib_data_h;
    logic        ib_take_h;
    logic [3:0]  mux_h;
    logic        long_lit_l;
    logic [31:0] lit_h;
    logic        busy_h;
    logic        stall_h;
    logic        done_h;

    alk_lit_seq dut (
        .clk_h      (clk_h),
        .reset_h    (reset_h),
        .start_h    (start_h),
        .size_h     (size_h),
        .abort_h    (abort_h),
        .ib_valid_h (ib_valid_h),
        .ib_data_h  (ib_data_h),
        .ib_take_h  (ib_take_h),
        .mux_h      (mux_h),
        .long_lit_l (long_lit_l),
        .lit_h      (lit_h),
        .busy_h     (busy_h),
        .stall_h    (stall_h),
        .done_h     (done_h)
    );

    always #5 clk_h = ~clk_h;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk_h) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        take;
        logic [3:0]  mux;
        logic        long_l;
        logic        busy;
        logic        stall;
        logic        done;
        logic        chk_lit;
        logic [31:0] lit;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] lit_q[$];

    // Literal-fetch model: is a fetch open, how many words it still needs,
    // the words gathered so far, and whether a completed literal is being announced.
    bit          m_active;
    bit          m_long;
    bit          m_done;
    int          m_got;
    logic [15:0] m_w[2];
    logic [31:0] m_lit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_long   = 0;
        m_done   = 0;
        m_got    = 0;
        m_lit    = '0;
    endtask

    // One clock cycle of stimulus: drive inputs just after the rising edge,
    // optionally pulse reset in mid-cycle, queue the expectation, advance the model.
    task automatic cycle(input bit st, input bit sz, input bit v, input logic [15:0] d,
                         input bit ab, input bit do_rst);
        exp_t e;
        int   sx;
        @(posedge clk_h);
        #1;
        start_h    = st;
        size_h     = sz;
        ib_valid_h = v;
        ib_data_h  = d;
        abort_h    = ab;
        if (do_rst) begin
            #1 reset_h = 1'b1;
            #1;
            check("rst_busy",  busy_h,     0);
            check("rst_mux",   mux_h,      0);
            check("rst_longl", long_lit_l, 1);
            check("rst_lit",   lit_h,      0);
            check("rst_done",  done_h,     0);
            check("rst_take",  ib_take_h,  0);
            check("rst_stall", stall_h,    st);
            #1 reset_h = 1'b0;
            model_reset();
        end

        e.cyc     = cyc;
        e.busy    = m_active;
        e.take    = m_active && v && !ab;
        e.mux     = !m_active ? 4'b0000 : (m_got == 0 ? 4'b0100 : 4'b0101);
        e.long_l  = !(m_active && m_long);
        e.stall   = m_active || (!m_done && st);
        e.done    = m_done && !ab;
        e.chk_lit = !m_active;
        e.lit     = m_lit;
        exp_q.push_back(e);
        if (e.done) lit_q.push_back(m_lit);

        if (ab) begin
            m_active = 0;
            m_done   = 0;
            m_got    = 0;
            m_lit    = '0;
        end else if (m_active) begin
            if (v) begin
                m_w[m_got] = d;
                m_got++;
                if (m_got == (m_long ? 2 : 1)) begin
                    sx       = $signed(m_w[0]);
                    m_lit    = m_long ? {m_w[1], m_w[0]} : sx;
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end else begin
            m_done = 0;
            if (st) begin
                m_active = 1;
                m_long   = sz;
                m_got    = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 16'h0000, 0, 0);
    endtask

    // Monitor: compare every cycle's outputs, and the literal on each done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_h);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rec_cyc", cyc,        e.cyc);
                check("take",    ib_take_h,  e.take);
                check("mux",     mux_h,      e.mux);
                check("long_l",  long_lit_l, e.long_l);
                check("busy",    busy_h,     e.busy);
                check("stall",   stall_h,    e.stall);
                check("done",    done_h,     e.done);
                if (e.chk_lit) check("lit_hold", lit_h, e.lit);
            end
            if (done_h === 1'b1) begin
                check("done_expected", lit_q.size() != 0, 1);
                if (lit_q.size() != 0) check("done_lit", lit_h, lit_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_h    = 1'b1;
        start_h    = 1'b0;
        size_h     = 1'b0;
        abort_h    = 1'b0;
        ib_valid_h = 1'b0;
        ib_data_h  = '0;
        model_reset();
        repeat (3) @(posedge clk_h);
        #2;
        check("reset_busy",  busy_h,     0);
        check("reset_mux",   mux_h,      0);
        check("reset_longl", long_lit_l, 1);
        check("reset_lit",   lit_h,      0);
        check("reset_done",  done_h,     0);
        check("reset_stall", stall_h,    0);
        check("reset_take",  ib_take_h,  0);
        reset_h = 1'b0;

        // Longword, both halves back-to-back.
        cycle(1, 1, 0, 16'h0000, 0, 0);
        cycle(0, 0, 1, 16'h1234, 0, 0);
        cycle(0, 0, 1, 16'hABCD, 0, 0);
        idle(2);

        // Word with sign extension.
        cycle(1, 0, 0, 16'h0000, 0, 0);
        cycle(0, 0, 1, 16'h8001, 0, 0);
        idle(2);

        // Longword with a 3-cycle buffer stall in HI; start_h ignored meanwhile.
        cycle(1, 1, 0, 16'h0000, 0, 0);
        cycle(0, 0, 1, 16'h1111, 0, 0);
        cycle(1, 0, 0, 16'hDEAD, 0, 0);
        cycle(1, 1, 0, 16'hBEEF, 0, 0);
        cycle(0, 0, 0, 16'hCAFE, 0, 0);
        cycle(0, 0, 1, 16'h2222, 0, 0);
        idle(2);

        // Abort in HI with a valid word present.
        cycle(1, 1, 0, 16'h0000, 0, 0);
        cycle(0, 0, 1, 16'h5555, 0, 0);
        cycle(0, 0, 1, 16'h6666, 1, 0);
        idle(3);

        // Back-to-back literals: start during DONE.
        cycle(1, 0, 0, 16'h0000, 0, 0);
        cycle(0, 0, 1, 16'h7FFF, 0, 0);
        cycle(1, 1, 0, 16'h0000, 0, 0);
        cycle(0, 0, 1, 16'h0F0F, 0, 0);
        cycle(0, 0, 1, 16'hF0F0, 0, 0);
        idle(2);

        // Asynchronous reset mid-LO, then a normal word.
        cycle(1, 1, 0, 16'h0000, 0, 0);
        cycle(0, 0, 0, 16'h3333, 0, 1);
        cycle(1, 0, 0, 16'h0000, 0, 0);
        cycle(0, 0, 1, 16'hC003, 0, 0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) < 3, 1'($urandom), $urandom_range(0, 9) < 6,
                  16'($urandom), $urandom_range(0, 49) == 0, $urandom_range(0, 399) == 0);
        end
        idle(4);

        @(negedge clk_h);
        #1;
        check("exp_drained", exp_q.size(), 0);
        check("lit_drained", lit_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
